// File: rtl/coreabc_ram_dp.sv
// Simple dual-port synchronous RAM: write-first bypass, 1- or 2-cycle read latency, power-on clear.
// Optional per-word parity storage and checking under COREABC_RAM_PARITY_EN.
module coreabc_ram_dp #(
  parameter int DWIDTH         = 8,
  parameter int AWIDTH         = 8,
  parameter int RDLAT          = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              rwclk_i,
  input  logic              reset_i,
  input  logic              wen_i,
  input  logic              ren_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [AWIDTH-1:0] raddr_i,
  input  logic [DWIDTH-1:0] wd_i,
`ifdef COREABC_RAM_PARITY_EN
  input  logic              pinj_i,
  output logic              perr_o,
`endif
  output logic [DWIDTH-1:0] rd_o,
  output logic              rvalid_o,
  output logic              busy_o
);

`ifdef COREABC_RAM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int AW    = DWIDTH + PW;
  localparam int DEPTH = 1 << AWIDTH;

  generate
    if (RDLAT != 1 && RDLAT != 2) begin : g_bad_rdlat
      $error("coreabc_ram_dp: RDLAT must be 1 or 2");
    end
  endgenerate

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  typedef struct packed {
    logic              en;
    logic [AWIDTH-1:0] addr;
    logic [AW-1:0]     data;
  } wr_req_t;

  state_e                 state_q, state_d;
  logic [AWIDTH-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]          mem_q [DEPTH];
  logic [AW-1:0]          wr_word, rd_word;
  wr_req_t                wr_req;
  logic                   rd_acc;
  logic [RDLAT:0]         vld_pipe;
  logic [RDLAT:1]         vld_q;
  logic [RDLAT:1][AW-1:0] dat_q;

`ifdef COREABC_RAM_PARITY_EN
  assign wr_word = {(^wd_i) ^ pinj_i, wd_i};
`else
  assign wr_word = wd_i;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {AWIDTH{1'b1}}) state_d = S_RUN;
    end
  end

  always_ff @(posedge rwclk_i) begin
    if (reset_i) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q == S_CLEAR);

  // Clear sequencer owns the write port while busy; an all-zero word has even parity.
  always_comb begin
    wr_req = '0;
    if (!reset_i) begin
      if (busy_o) begin
        wr_req.en   = 1'b1;
        wr_req.addr = cnt_q;
      end else if (wen_i) begin
        wr_req.en   = 1'b1;
        wr_req.addr = waddr_i;
        wr_req.data = wr_word;
      end
    end
  end

  always_ff @(posedge rwclk_i) begin
    if (wr_req.en) mem_q[wr_req.addr] <= wr_req.data;
  end

  assign rd_acc   = !reset_i && !busy_o && ren_i;
  assign rd_word  = (wen_i && (waddr_i == raddr_i)) ? wr_word : mem_q[raddr_i];
  assign vld_pipe = {vld_q, rd_acc};

  // Data stages only advance on a valid beat so RD holds between reads.
  always_ff @(posedge rwclk_i) begin
    if (reset_i) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_pipe[RDLAT-1:0];
      if (rd_acc) dat_q[1] <= rd_word;
      for (int k = 2; k <= RDLAT; k++)
        if (vld_pipe[k-1]) dat_q[k] <= dat_q[k-1];
    end
  end

  assign rd_o     = dat_q[RDLAT][DWIDTH-1:0];
  assign rvalid_o = vld_pipe[RDLAT];
`ifdef COREABC_RAM_PARITY_EN
  assign perr_o   = vld_pipe[RDLAT] & ((^dat_q[RDLAT][DWIDTH-1:0]) ^ dat_q[RDLAT][DWIDTH]);
`endif

endmodule

// File: tb/tb_coreabc_ram_dp.sv
// Bench: three RAM instances (RDLAT=1 clear, RDLAT=2 clear, RDLAT=1 no-clear) on shared stimulus,
// checked every cycle against an array/queue reference model.
module tb_coreabc_ram_dp;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0, wen = 1'b0, ren = 1'b0, pinj = 1'b0;
  logic [AW-1:0] waddr = '0, raddr = '0;
  logic [7:0]    wd = '0;
  logic [7:0]    rd_a, rd_b, rd_c;
  logic          rv_a, rv_b, rv_c, busy_a, busy_b, busy_c;
`ifdef COREABC_RAM_PARITY_EN
  logic          perr_a, perr_b, perr_c;
`endif

  always #5 clk = ~clk;

  coreabc_ram_dp #(.DWIDTH(8), .AWIDTH(AW), .RDLAT(1), .CLEAR_ON_RESET(1)) dut_a (
    .rwclk_i(clk), .reset_i(rst), .wen_i(wen), .ren_i(ren), .waddr_i(waddr), .raddr_i(raddr),
    .wd_i(wd),
`ifdef COREABC_RAM_PARITY_EN
    .pinj_i(pinj), .perr_o(perr_a),
`endif
    .rd_o(rd_a), .rvalid_o(rv_a), .busy_o(busy_a));

  coreabc_ram_dp #(.DWIDTH(8), .AWIDTH(AW), .RDLAT(2), .CLEAR_ON_RESET(1)) dut_b (
    .rwclk_i(clk), .reset_i(rst), .wen_i(wen), .ren_i(ren), .waddr_i(waddr), .raddr_i(raddr),
    .wd_i(wd),
`ifdef COREABC_RAM_PARITY_EN
    .pinj_i(pinj), .perr_o(perr_b),
`endif
    .rd_o(rd_b), .rvalid_o(rv_b), .busy_o(busy_b));

  coreabc_ram_dp #(.DWIDTH(8), .AWIDTH(AW), .RDLAT(1), .CLEAR_ON_RESET(0)) dut_c (
    .rwclk_i(clk), .reset_i(rst), .wen_i(wen), .ren_i(ren), .waddr_i(waddr), .raddr_i(raddr),
    .wd_i(wd),
`ifdef COREABC_RAM_PARITY_EN
    .pinj_i(pinj), .perr_o(perr_c),
`endif
    .rd_o(rd_c), .rvalid_o(rv_c), .busy_o(busy_c));

  int ntests = 0;
  int nfail  = 0;

  // Reference model: words plus "parity was corrupted" flag per address.
  logic [7:0] m1 [DEPTH];
  logic [7:0] m0 [DEPTH];
  bit         p1 [DEPTH];
  bit         p0 [DEPTH];
  bit         busy1;
  int         cnt1;
  bit         ea_v, eb_v, ec_v, pend_v, ea_p, eb_p, ec_p, pend_p;
  logic [7:0] ea_d = '0, eb_d = '0, ec_d = '0, pend_d = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit we, input bit re, input logic [AW-1:0] wa,
                       input logic [AW-1:0] ra, input logic [7:0] d, input bit pi);
    bit         nv, np, byp;
    logic [7:0] nd;
    nv  = 1'b0; np = 1'b0; nd = '0;
    byp = we && (wa == ra);
    if (r) begin
      busy1 = 1'b1; cnt1 = 0; pend_v = 1'b0;
      ea_v = 1'b0; ea_d = '0; eb_v = 1'b0; eb_d = '0;
    end else begin
      if (busy1) begin
        m1[cnt1] = '0; p1[cnt1] = 1'b0; cnt1++;
        if (cnt1 == DEPTH) busy1 = 1'b0;
      end else begin
        if (re) begin
          nv = 1'b1;
          nd = byp ? d : m1[ra];
          np = byp ? pi : p1[ra];
        end
        if (we) begin m1[wa] = d; p1[wa] = pi; end
      end
      ea_v = nv;
      if (nv) begin ea_d = nd; ea_p = np; end
      eb_v = pend_v;
      if (pend_v) begin eb_d = pend_d; eb_p = pend_p; end
      pend_v = nv; pend_d = nd; pend_p = np;
    end
    if (r) begin
      ec_v = 1'b0; ec_d = '0;
    end else begin
      ec_v = re;
      if (re) begin ec_d = byp ? d : m0[ra]; ec_p = byp ? pi : p0[ra]; end
      if (we) begin m0[wa] = d; p0[wa] = pi; end
    end
  endtask

  task automatic check_all();
    chk("busy_a", 32'(busy_a), 32'(busy1));
    chk("busy_b", 32'(busy_b), 32'(busy1));
    chk("busy_c", 32'(busy_c), 32'd0);
    chk("rvalid_a", 32'(rv_a), 32'(ea_v));
    chk("rvalid_b", 32'(rv_b), 32'(eb_v));
    chk("rvalid_c", 32'(rv_c), 32'(ec_v));
    chk("rd_a", 32'(rd_a), 32'(ea_d));
    chk("rd_b", 32'(rd_b), 32'(eb_d));
    chk("rd_c", 32'(rd_c), 32'(ec_d));
`ifdef COREABC_RAM_PARITY_EN
    chk("perr_a", 32'(perr_a), 32'(ea_v & ea_p));
    chk("perr_b", 32'(perr_b), 32'(eb_v & eb_p));
    chk("perr_c", 32'(perr_c), 32'(ec_v & ec_p));
`endif
  endtask

  task automatic cyc(input bit r, input bit we, input bit re, input logic [AW-1:0] wa,
                     input logic [AW-1:0] ra, input logic [7:0] d, input bit pi);
    rst = r; wen = we; ren = re; waddr = wa; raddr = ra; wd = d; pinj = pi;
    @(posedge clk);
    model(r, we, re, wa, ra, d, pi);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    // Reset, then hammer writes during the clear (instance c accepts them, a/b must not).
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b0, 1'b1, 1'b1, AW'(i), AW'(i), (i == 3) ? 8'hAA : 8'($urandom), 1'b0);
    // Back-to-back reads of every address.
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 1'b1, '0, AW'(i), '0, 1'b0);
    idle(3);
    // Latency.
    cyc(1'b0, 1'b1, 1'b0, 6'h10, '0, 8'h5A, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, '0, 6'h10, '0, 1'b0);
    idle(3);
    // Write-first bypass and independent addresses.
    cyc(1'b0, 1'b1, 1'b0, 6'h22, '0, 8'h11, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 6'h23, '0, 8'h77, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 6'h22, 6'h22, 8'h3C, 1'b0);
    idle(2);
    cyc(1'b0, 1'b1, 1'b0, 6'h22, '0, 8'h11, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 6'h22, 6'h23, 8'h3C, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, '0, 6'h22, '0, 1'b0);
    idle(3);
    // Parity: clean word, injected word, injected bypass.
    cyc(1'b0, 1'b1, 1'b0, 6'h30, '0, 8'h81, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, '0, 6'h30, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 6'h30, '0, 8'h81, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, '0, 6'h30, '0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 6'h31, 6'h31, 8'h81, 1'b1);
    idle(3);
    // Reset mid-clear at count 7, with random traffic that must be ignored by a/b.
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    idle(7);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++)
      cyc(1'b0, 1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom), 8'($urandom), 1'b0);
    // Reset one cycle after a read squashes it.
    cyc(1'b0, 1'b0, 1'b1, '0, 6'h10, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    idle(DEPTH + 1);
    // No-clear instance keeps contents across reset.
    cyc(1'b0, 1'b1, 1'b0, 6'h05, '0, 8'h99, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, '0, 6'h05, '0, 1'b0);
    idle(DEPTH + 1);
    // Random traffic with occasional reset and parity injection.
    for (int i = 0; i < 500; i++) begin
      logic [AW-1:0] wa, ra;
      wa = AW'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      cyc($urandom_range(0, 199) == 0, 1'($urandom), 1'($urandom), wa, ra, 8'($urandom),
          $urandom_range(0, 7) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
